// File: rtl/sound_pkg.sv
// Shared types and tune tables for the game sound sequencer.
// Tunes are stored as fixed 4-entry note lists padded with silent entries.
package sound_pkg;

    typedef enum logic {
        OFF = 1'b0,
        ON  = 1'b1
    } MODE_TYPES;

    // Encoding doubles as arbitration priority: larger value wins.
    typedef enum logic [1:0] {
        TUNE_NONE  = 2'd0,
        TUNE_EAT   = 2'd1,
        TUNE_START = 2'd2,
        TUNE_DIE   = 2'd3
    } tune_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_PLAY = 2'd1,
        S_GAP  = 2'd2
    } seq_state_e;

    typedef struct packed {
        logic [7:0] freq;
        logic [3:0] dur;
    } note_t;

    localparam int MAX_NOTES = 4;
    localparam int EAT_LEN   = 1;
    localparam int START_LEN = 3;
    localparam int DIE_LEN   = 4;

    localparam note_t EAT_TUNE [MAX_NOTES] = '{
        '{8'd40, 4'd2}, '{8'd0, 4'd0}, '{8'd0, 4'd0}, '{8'd0, 4'd0}
    };
    localparam note_t START_TUNE [MAX_NOTES] = '{
        '{8'd80, 4'd2}, '{8'd60, 4'd2}, '{8'd40, 4'd4}, '{8'd0, 4'd0}
    };
    localparam note_t DIE_TUNE [MAX_NOTES] = '{
        '{8'd50, 4'd3}, '{8'd70, 4'd3}, '{8'd100, 4'd3}, '{8'd150, 4'd6}
    };

endpackage

// File: rtl/sound_note_rom.sv
// Combinational note lookup: (tune, note index) -> note and last-note flag.
module sound_note_rom
    import sound_pkg::*;
(
    input  tune_e      tune_i,
    input  logic [1:0] idx_i,
    output note_t      note_o,
    output logic       last_o
);

    always_comb begin
        note_o = '0;
        last_o = 1'b1;
        case (tune_i)
            TUNE_EAT: begin
                note_o = EAT_TUNE[idx_i];
                last_o = (idx_i == 2'(EAT_LEN - 1));
            end
            TUNE_START: begin
                note_o = START_TUNE[idx_i];
                last_o = (idx_i == 2'(START_LEN - 1));
            end
            TUNE_DIE: begin
                note_o = DIE_TUNE[idx_i];
                last_o = (idx_i == 2'(DIE_LEN - 1));
            end
            default: begin
                note_o = '0;
                last_o = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/sound_sequencer.sv
// Arbitrates game sound requests and plays fixed tunes on the oscillator.
// Optional SOUND_PREEMPT_EN: a higher-priority request aborts the tune in progress.
module sound_sequencer
    import sound_pkg::*;
#(
    parameter int TICK_DIV = 1000
) (
    input  logic       clk,
    input  logic       nRst,
    input  MODE_TYPES  state,
    input  logic       req_start,
    input  logic       req_eat,
    input  logic       req_die,
    output logic [7:0] freq,
    output logic       playSound,
    output logic       busy,
    output logic [1:0] tune_id
);

    localparam int TICK_W = $clog2(TICK_DIV);
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);

    seq_state_e        state_q, state_d;
    logic [TICK_W-1:0] tick_q, tick_d;
    logic [3:0]        dur_q, dur_d;
    logic [1:0]        idx_q, idx_d;
    tune_e             tune_q, tune_d;
    logic              last_q, last_d;
    logic [7:0]        freq_q, freq_d;
    logic              play_q, play_d;
    logic              busy_q, busy_d;

    tune_e      req_tune;
    logic       launch;
    logic       preempt_ok;
    tune_e      rom_tune;
    logic [1:0] rom_idx;
    note_t      note;
    logic       note_last;
    logic [3:0] dur_eff;

    always_comb begin
        if (req_die)        req_tune = TUNE_DIE;
        else if (req_start) req_tune = TUNE_START;
        else if (req_eat)   req_tune = TUNE_EAT;
        else                req_tune = TUNE_NONE;
    end

`ifdef SOUND_PREEMPT_EN
    assign preempt_ok = (state_q != S_IDLE) && (req_tune > tune_q);
`else
    assign preempt_ok = 1'b0;
`endif

    assign launch = (state == ON) && (req_tune != TUNE_NONE) &&
                    ((state_q == S_IDLE) || preempt_ok);

    // In GAP, idx_q already points at the upcoming note so its freq is ready.
    assign rom_tune = launch ? req_tune : tune_q;
    assign rom_idx  = launch ? 2'd0 : idx_q;
    assign dur_eff  = (note.dur == 4'd0) ? 4'd1 : note.dur;

    sound_note_rom u_rom (
        .tune_i (rom_tune),
        .idx_i  (rom_idx),
        .note_o (note),
        .last_o (note_last)
    );

    always_comb begin
        state_d = state_q;
        tick_d  = tick_q;
        dur_d   = dur_q;
        idx_d   = idx_q;
        tune_d  = tune_q;
        last_d  = last_q;
        freq_d  = freq_q;
        play_d  = play_q;
        busy_d  = busy_q;

        if (state == OFF) begin
            state_d = S_IDLE;
            tick_d  = '0;
            dur_d   = '0;
            idx_d   = '0;
            tune_d  = TUNE_NONE;
            last_d  = 1'b0;
            freq_d  = '0;
            play_d  = 1'b0;
            busy_d  = 1'b0;
        end else if (launch) begin
            state_d = S_PLAY;
            tick_d  = '0;
            dur_d   = '0;
            idx_d   = '0;
            tune_d  = req_tune;
            last_d  = 1'b0;
            freq_d  = note.freq;
            play_d  = (note.freq != 8'd0);
            busy_d  = 1'b1;
        end else begin
            case (state_q)
                S_PLAY: begin
                    tick_d = (tick_q == TICK_LAST) ? '0 : tick_q + 1'b1;
                    if (tick_q == TICK_LAST) begin
                        if (dur_q == dur_eff - 4'd1) begin
                            state_d = S_GAP;
                            dur_d   = '0;
                            idx_d   = idx_q + 2'd1;
                            last_d  = note_last;
                            freq_d  = '0;
                            play_d  = 1'b0;
                        end else begin
                            dur_d = dur_q + 4'd1;
                        end
                    end
                end
                S_GAP: begin
                    tick_d = (tick_q == TICK_LAST) ? '0 : tick_q + 1'b1;
                    if (tick_q == TICK_LAST) begin
                        if (last_q) begin
                            state_d = S_IDLE;
                            idx_d   = '0;
                            tune_d  = TUNE_NONE;
                            last_d  = 1'b0;
                            busy_d  = 1'b0;
                        end else begin
                            state_d = S_PLAY;
                            freq_d  = note.freq;
                            play_d  = (note.freq != 8'd0);
                        end
                    end
                end
                default: begin
                    tick_d = '0;
                    dur_d  = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            state_q <= S_IDLE;
            tick_q  <= '0;
            dur_q   <= '0;
            idx_q   <= '0;
            tune_q  <= TUNE_NONE;
            last_q  <= 1'b0;
            freq_q  <= '0;
            play_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            tick_q  <= tick_d;
            dur_q   <= dur_d;
            idx_q   <= idx_d;
            tune_q  <= tune_d;
            last_q  <= last_d;
            freq_q  <= freq_d;
            play_q  <= play_d;
            busy_q  <= busy_d;
        end
    end

    assign freq      = freq_q;
    assign playSound = play_q;
    assign busy      = busy_q;
    assign tune_id   = tune_q;

endmodule

// File: tb/tb_sound_sequencer.sv
// Bench for sound_sequencer (TICK_DIV=4): directed scenarios plus random requests
// checked cycle by cycle against a timeline model built from the tune tables.
module tb_sound_sequencer;
    import sound_pkg::*;

    localparam int TD = 4;
`ifdef SOUND_PREEMPT_EN
    localparam bit PREEMPT = 1'b1;
`else
    localparam bit PREEMPT = 1'b0;
`endif

    logic       clk;
    logic       nRst;
    MODE_TYPES  state_in;
    logic       req_start, req_eat, req_die;
    logic [7:0] freq;
    logic       playSound, busy;
    logic [1:0] tune_id;

    sound_sequencer #(.TICK_DIV(TD)) dut (
        .clk       (clk),
        .nRst      (nRst),
        .state     (state_in),
        .req_start (req_start),
        .req_eat   (req_eat),
        .req_die   (req_die),
        .freq      (freq),
        .playSound (playSound),
        .busy      (busy),
        .tune_id   (tune_id)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int f;
        bit p;
        bit b;
        int id;
    } exp_t;

    // Tune tables indexed by tune id (0 none, 1 eat, 2 start, 3 die).
    int tf [4][4] = '{'{0, 0, 0, 0}, '{40, 0, 0, 0}, '{80, 60, 40, 0}, '{50, 70, 100, 150}};
    int td [4][4] = '{'{0, 0, 0, 0}, '{2, 0, 0, 0}, '{2, 2, 4, 0}, '{3, 3, 3, 6}};
    int tl [4]    = '{0, 1, 3, 4};

    exp_t q[$];
    exp_t cur;
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;

    function automatic exp_t idle_e();
        exp_t e;
        e.f = 0; e.p = 1'b0; e.b = 1'b0; e.id = 0;
        return e;
    endfunction

    task automatic build(input int rt);
        exp_t e;
        int d;
        q.delete();
        for (int n = 0; n < tl[rt]; n++) begin
            d = (td[rt][n] == 0) ? 1 : td[rt][n];
            for (int k = 0; k < d * TD; k++) begin
                e.f = tf[rt][n]; e.p = (tf[rt][n] != 0); e.b = 1'b1; e.id = rt;
                q.push_back(e);
            end
            for (int k = 0; k < TD; k++) begin
                e.f = 0; e.p = 1'b0; e.b = 1'b1; e.id = rt;
                q.push_back(e);
            end
        end
    endtask

    task automatic model(input bit rs, input bit re, input bit rd, input bit on);
        int rt;
        if (!nRst || !on) begin
            q.delete();
            cur = idle_e();
        end else begin
            rt = rd ? 3 : (rs ? 2 : (re ? 1 : 0));
            if (rt != 0 && (!cur.b || (PREEMPT && rt > cur.id)))
                build(rt);
            if (q.size() > 0) cur = q.pop_front();
            else              cur = idle_e();
        end
    endtask

    task automatic check_outputs();
        checks++;
        assert (freq === 8'(cur.f)) else begin
            errors++;
            $error("FAIL freq cyc=%0d observed=%0d expected=%0d", cyc, freq, cur.f);
        end
        checks++;
        assert (playSound === cur.p) else begin
            errors++;
            $error("FAIL playSound cyc=%0d observed=%0b expected=%0b", cyc, playSound, cur.p);
        end
        checks++;
        assert (busy === cur.b) else begin
            errors++;
            $error("FAIL busy cyc=%0d observed=%0b expected=%0b", cyc, busy, cur.b);
        end
        checks++;
        assert (tune_id === 2'(cur.id)) else begin
            errors++;
            $error("FAIL tune_id cyc=%0d observed=%0d expected=%0d", cyc, tune_id, cur.id);
        end
    endtask

    task automatic cycle(input bit rs, input bit re, input bit rd, input bit on);
        req_start = rs;
        req_eat   = re;
        req_die   = rd;
        state_in  = on ? ON : OFF;
        @(posedge clk);
        cyc++;
        model(rs, re, rd, on);
        #1;
        check_outputs();
        req_start = 1'b0;
        req_eat   = 1'b0;
        req_die   = 1'b0;
    endtask

    task automatic idle_cycles(input int n, input bit on);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 1'b0, on);
    endtask

    task automatic async_reset();
        #2;
        nRst = 1'b0;
        #1;
        q.delete();
        cur = idle_e();
        check_outputs();
        idle_cycles(2, 1'b1);
        nRst = 1'b1;
    endtask

    initial begin
        nRst      = 1'b0;
        state_in  = ON;
        req_start = 1'b0;
        req_eat   = 1'b0;
        req_die   = 1'b0;
        cur       = idle_e();
        #12;
        check_outputs();
        idle_cycles(2, 1'b1);
        nRst = 1'b1;
        idle_cycles(2, 1'b1);

        // Single eat sound through to idle.
        cycle(1'b0, 1'b1, 1'b0, 1'b1);
        idle_cycles(15, 1'b1);

        // Eat and die together: die wins.
        cycle(1'b0, 1'b1, 1'b1, 1'b1);
        idle_cycles(82, 1'b1);

        // Repeated start request during start note 0.
        cycle(1'b1, 1'b0, 1'b0, 1'b1);
        idle_cycles(3, 1'b1);
        cycle(1'b1, 1'b0, 1'b0, 1'b1);
        idle_cycles(45, 1'b1);

        // OFF during start note 1, requests while OFF, then ON again.
        cycle(1'b1, 1'b0, 1'b0, 1'b1);
        idle_cycles(14, 1'b1);
        cycle(1'b0, 1'b0, 1'b0, 1'b0);
        cycle(1'b0, 1'b1, 1'b1, 1'b0);
        idle_cycles(6, 1'b1);

        // Die during eat (preempts only when enabled), eat during die.
        cycle(1'b0, 1'b1, 1'b0, 1'b1);
        idle_cycles(3, 1'b1);
        cycle(1'b0, 1'b0, 1'b1, 1'b1);
        idle_cycles(5, 1'b1);
        cycle(1'b0, 1'b1, 1'b0, 1'b1);
        idle_cycles(85, 1'b1);

        // Async reset in the middle of die note 2.
        cycle(1'b0, 1'b0, 1'b1, 1'b1);
        idle_cycles(37, 1'b1);
        async_reset();
        idle_cycles(4, 1'b1);

        // Random request traffic with occasional OFF cycles.
        for (int i = 0; i < 1500; i++) begin
            cycle(($urandom_range(0, 99) < 3), ($urandom_range(0, 99) < 4),
                  ($urandom_range(0, 99) < 2), ($urandom_range(0, 149) != 0));
        end
        idle_cycles(90, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
